piece_plotter: RTL and testbench



---
 rtl/vetris_pkg.sv | 39 +++
 rtl/piece_row_mask.sv | 48 ++++
 rtl/piece_plotter.sv | 114 +++++++++++
 tb/tb_piece_plotter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vetris_pkg.sv
/******************************************************************************
 * Module   : vetris_pkg
 * Brief    : Board geometry, piece-word field layout, shape/op codes and
 *            plotter FSM states shared by the board-update engine.
 * Revision : 1.0  initial release
 ******************************************************************************/
`default_nettype none

package vetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ROW_AW  = 5;

  localparam int X_LSB   = 3;
  localparam int Y_LSB   = 7;
  localparam int SHP_LSB = 13;

  localparam logic [1:0] SHP_NONE   = 2'b00;
  localparam logic [1:0] SHP_LINE   = 2'b01;
  localparam logic [1:0] SHP_SQUARE = 2'b10;

  typedef enum logic [1:0] {
    OP_DRAW   = 2'b00,
    OP_ERASE  = 2'b01,
    OP_CHECK  = 2'b10,
    OP_CHECK2 = 2'b11
  } plot_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_MOD  = 2'b10,
    ST_DONE = 2'b11
  } plot_state_t;

endpackage : vetris_pkg

`default_nettype wire

// File: rtl/piece_row_mask.sv
/******************************************************************************
 * Module   : piece_row_mask
 * Brief    : Shape/x decode into a per-row column mask, row count and a flag
 *            for mask bits that fall off the right edge of the board.
 * Revision : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module piece_row_mask
  import vetris_pkg::*;
(
  input  logic [1:0]         i_shape,
  input  logic [4:0]         i_x,
  output logic [BOARD_W-1:0] o_mask,
  output logic [2:0]         o_rows,
  output logic               o_col_off
);

  // Wide enough that a 2-bit pattern shifted by the largest x never wraps.
  localparam int FULL_W = 34;

  logic [FULL_W-1:0] w_full;

  always_comb begin
    w_full = '0;
    o_rows = 3'd0;
    case (i_shape)
      SHP_LINE: begin
        w_full = FULL_W'(1) << i_x;
        o_rows = 3'd4;
      end
      SHP_SQUARE: begin
        w_full = FULL_W'(3) << i_x;
        o_rows = 3'd2;
      end
      default: begin
        w_full = '0;
        o_rows = 3'd0;
      end
    endcase
  end

  assign o_mask    = w_full[BOARD_W-1:0];
  assign o_col_off = |w_full[FULL_W-1:BOARD_W];

endmodule : piece_row_mask

`default_nettype wire

// File: rtl/piece_plotter.sv
/******************************************************************************
 * Module   : piece_plotter
 * Brief    : Row-by-row read-modify-write engine that draws, erases or
 *            collision-checks a packed piece against the board RAM.
 * Revision : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module piece_plotter
  import vetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_piece,
  input  logic [1:0]         in_op,
  output logic               done,
  output logic               collide,
  output logic [ROW_AW-1:0]  mem_addr,
  output logic               mem_re,
  input  logic [BOARD_W-1:0] mem_rdata,
  output logic               mem_we,
  output logic [BOARD_W-1:0] mem_wdata
);

  plot_state_t        r_state;
  plot_op_t           r_op;
  logic [1:0]         r_k;
  logic [1:0]         r_last;
  logic [5:0]         r_y;
  logic [BOARD_W-1:0] r_mask;
  logic               r_col_off;
  logic               r_coll;

  logic [BOARD_W-1:0] w_mask;
  logic [2:0]         w_rows;
  logic               w_col_off;
  logic [6:0]         w_row;
  logic               w_row_off;
  logic               w_wr;
  logic               w_hit;
  logic               w_accept;
  logic               w_unused_bits;

  assign w_unused_bits = ^{in_piece[31:15], in_piece[2:0]};

  piece_row_mask u_mask (
    .i_shape   (in_piece[SHP_LSB+1:SHP_LSB]),
    .i_x       ({1'b0, in_piece[X_LSB+3:X_LSB]}),
    .o_mask    (w_mask),
    .o_rows    (w_rows),
    .o_col_off (w_col_off)
  );

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_row     = 7'(r_y) + 7'(r_k);
  assign w_row_off = (w_row > 7'(BOARD_H - 1));
  assign w_wr      = (r_state == ST_MOD) && !w_row_off &&
                     ((r_op == OP_DRAW) || (r_op == OP_ERASE));
  assign w_hit     = (r_op != OP_ERASE) && !w_row_off && (|(mem_rdata & r_mask));

  assign in_ready  = (r_state == ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign collide   = (r_state == ST_DONE) ? r_coll : 1'b0;
  assign mem_re    = (r_state == ST_RD) && !w_row_off;
  assign mem_we    = w_wr;
  assign mem_addr  = ((r_state == ST_RD) || (r_state == ST_MOD)) ? w_row[ROW_AW-1:0] : '0;
  assign mem_wdata = !w_wr ? '0 :
                     (r_op == OP_DRAW) ? (mem_rdata | r_mask) : (mem_rdata & ~r_mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_DRAW;
      r_k       <= 2'd0;
      r_last    <= 2'd0;
      r_y       <= 6'd0;
      r_mask    <= '0;
      r_col_off <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op      <= plot_op_t'(in_op);
            r_y       <= in_piece[Y_LSB+5:Y_LSB];
            r_mask    <= w_mask;
            r_col_off <= w_col_off;
            r_last    <= 2'(w_rows - 3'd1);
            r_k       <= 2'd0;
            r_coll    <= 1'b0;
            r_state   <= (w_rows == 3'd0) ? ST_DONE : ST_RD;
          end
        end
        ST_RD: r_state <= ST_MOD;
        ST_MOD: begin
          // Off-board geometry counts as a collision for every op.
          r_coll <= r_coll | r_col_off | w_row_off | w_hit;
          if (r_k == r_last) begin
            r_state <= ST_DONE;
          end else begin
            r_k     <= r_k + 2'd1;
            r_state <= ST_RD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : piece_plotter

`default_nettype wire

// File: tb/tb_piece_plotter.sv
/******************************************************************************
 * Module   : tb_piece_plotter
 * Brief    : Scoreboard bench for piece_plotter with a row-RAM model.
 * Revision : 1.0  initial release
 ******************************************************************************/
`default_nettype none

module tb_piece_plotter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [31:0] in_piece = 32'd0;
  logic [1:0] in_op = 2'd0;
  logic       done;
  logic       collide;
  logic [4:0] mem_addr;
  logic       mem_re;
  logic [9:0] mem_rdata = 10'd0;
  logic       mem_we;
  logic [9:0] mem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [9:0] board [0:31];

  int          exp_rd[$];
  logic [14:0] exp_wr[$];
  int          exp_done_cyc[$];
  logic        exp_done_coll[$];

  int accept_cyc;

  piece_plotter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_piece  (in_piece),
    .in_op     (in_op),
    .done      (done),
    .collide   (collide),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= board[mem_addr];
    if (mem_we) board[mem_addr] <= mem_wdata;
  end

  // Monitor: pops expectations whenever the DUT strobes or completes.
  always @(negedge clk) begin
    if (mem_re && mem_we) begin
      checks++; errors++;
      $display("FAIL strobe_overlap re=%0b we=%0b expected not both", mem_re, mem_we);
    end
    if (!done && collide) begin
      checks++; errors++;
      $display("FAIL collide_idle actual=%0b expected=0", collide);
    end
    if (mem_re) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected addr=%0d expected no read", mem_addr);
      end else begin
        int a;
        a = exp_rd.pop_front();
        if (int'(mem_addr) != a) begin
          errors++;
          $display("FAIL read_addr actual=%0d expected=%0d", mem_addr, a);
        end
      end
    end
    if (mem_we) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%0d data=%h expected no write", mem_addr, mem_wdata);
      end else begin
        logic [14:0] w;
        w = exp_wr.pop_front();
        if ({mem_addr, mem_wdata} != w) begin
          errors++;
          $display("FAIL write actual=%0d/%h expected=%0d/%h", mem_addr, mem_wdata, w[14:10], w[9:0]);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_done_cyc.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d expected no done", cyc);
      end else begin
        int  c;
        logic k;
        c = exp_done_cyc.pop_front();
        k = exp_done_coll.pop_front();
        if (cyc != c || collide != k) begin
          errors++;
          $display("FAIL done cyc=%0d collide=%0b expected cyc=%0d collide=%0b", cyc, collide, c, k);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Called at a negedge; holds in_valid until the DUT accepts.
  task automatic send(input logic [31:0] piece, input logic [1:0] op,
                      input int lat, input logic coll);
    int n;
    in_piece = piece;
    in_op    = op;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout piece=%h", piece);
    end
    accept_cyc = cyc;
    exp_done_cyc.push_back(cyc + lat);
    exp_done_coll.push_back(coll);
    @(negedge clk);
    in_valid = 1'b0;
    in_piece = 32'hDEAD_BEEF;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_done_cyc.size() != 0 || !in_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_done_cyc.size() != 0 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL drain pending done=%0d rd=%0d wr=%0d expected 0/0/0",
               exp_done_cyc.size(), exp_rd.size(), exp_wr.size());
    end
    exp_done_cyc.delete(); exp_done_coll.delete(); exp_rd.delete(); exp_wr.delete();
  endtask

  initial begin
    int d, n;
    for (int i = 0; i < 32; i++) board[i] = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_outs", {done, collide, mem_re, mem_we, mem_addr, mem_wdata}, 32'd0);

    // Line x=3 y=16 drawn on empty board.
    for (int r = 16; r < 20; r++) begin
      exp_rd.push_back(r);
      exp_wr.push_back({5'(r), 10'h008});
    end
    send(32'h0000_2818, 2'b00, 9, 1'b0);
    wait_drain();
    for (int r = 16; r < 20; r++) check("draw_line_board", 32'(board[r]), 32'h008);

    // Erase it, then a zero-row request offered during the done cycle.
    for (int r = 16; r < 20; r++) begin
      exp_rd.push_back(r);
      exp_wr.push_back({5'(r), 10'h000});
    end
    send(32'h0000_2818, 2'b01, 9, 1'b0);
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    d = cyc;
    check("done_seen", 32'(done), 32'd1);
    check("ready_in_done", 32'(in_ready), 32'd0);
    send(32'h0000_0000, 2'b11, 1, 1'b0);
    check("b2b_accept", 32'(accept_cyc), 32'(d + 1));
    wait_drain();
    for (int r = 16; r < 20; r++) check("erase_board", 32'(board[r]), 32'h000);

    // CHECK square x=8 y=0 against row0=0x100.
    @(negedge clk);
    board[0] = 10'h100;
    exp_rd.push_back(0);
    exp_rd.push_back(1);
    send(32'h0000_4040, 2'b10, 5, 1'b1);
    wait_drain();
    check("check_nowrite", 32'(board[0]), 32'h100);

    // DRAW square x=9 y=0: right column falls off the board.
    board[0] = 10'h000;
    exp_rd.push_back(0);
    exp_rd.push_back(1);
    exp_wr.push_back({5'd0, 10'h200});
    exp_wr.push_back({5'd1, 10'h200});
    send(32'h0000_4048, 2'b00, 5, 1'b1);
    wait_drain();

    // DRAW line x=0 y=18: rows 20,21 sequenced but not strobed.
    exp_rd.push_back(18);
    exp_rd.push_back(19);
    exp_wr.push_back({5'd18, 10'h001});
    exp_wr.push_back({5'd19, 10'h001});
    send(32'h0000_2900, 2'b00, 9, 1'b1);
    wait_drain();
    check("offboard_row20", 32'(board[20]), 32'h000);

    // Reset asserted in cycle T+4 of a line DRAW.
    board[18] = 10'h000;
    board[19] = 10'h000;
    exp_rd.push_back(16);
    exp_rd.push_back(17);
    exp_wr.push_back({5'd16, 10'h008});
    exp_wr.push_back({5'd17, 10'h008});
    send(32'h0000_2818, 2'b00, 9, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_reset_cyc", 32'(cyc), 32'(accept_cyc + 4));
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_outs", {done, collide, mem_re, mem_we, mem_addr, mem_wdata}, 32'd0);
    rst = 1'b0;
    exp_done_cyc.delete();
    exp_done_coll.delete();
    repeat (3) @(negedge clk);
    check("rst_pending", 32'(exp_rd.size() + exp_wr.size()), 32'd0);
    check("rst_row16", 32'(board[16]), 32'h008);
    check("rst_row17", 32'(board[17]), 32'h008);
    check("rst_row18", 32'(board[18]), 32'h000);
    check("rst_row19", 32'(board[19]), 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_piece_plotter

`default_nettype wire
